// File: rtl/eq_pkg.sv
// Shared types and defaults for the equaliser MAC scheduler.
package eq_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_WAIT_SEQ,
      S_RUN,
      S_DONE
   } sched_state_t;

   localparam int DFLT_TAPS   = 1021;
   localparam int DFLT_TO_CYC = 8;

endpackage

// File: rtl/seq_watchdog.sv
// Cycle watchdog: counts cycles since a readout start and flags expiry after TO_CYC.
module seq_watchdog #(
   parameter int TO_CYC = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expire
);

   localparam int CW = $clog2(TO_CYC + 1);
   localparam logic [CW-1:0] LIMIT = CW'(TO_CYC - 1);

   logic [CW-1:0] count;

   // The clearing cycle (q_start) is itself the first cycle of the window.
   always_ff @(posedge clk) begin
      if (rst)
         count <= '0;
      else if (clr)
         count <= CW'(1);
      else if (en && count < LIMIT)
         count <= count + CW'(1);
   end

   assign expire = en && (count >= LIMIT);

endmodule

// File: rtl/eq_seq_sched.sv
// Shares one FIR MAC between NUM_CH sample queues, sequencing each readout in turn.
// Optional build macro SEQ_LEN_CHK_EN adds the sticky err_len output.
module eq_seq_sched
   import eq_pkg::*;
#(
   parameter int NUM_CH   = 2,
   parameter int TAPS     = DFLT_TAPS,
   parameter int COEFF_AW = 10,
   parameter int TO_CYC   = DFLT_TO_CYC,
   localparam int CH_W    = $clog2(NUM_CH) + 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                wrt_smpl,
   input  logic [NUM_CH-1:0]   seq_in,
   input  logic                ovr_clr,
   output logic [NUM_CH-1:0]   q_start,
   output logic [CH_W-1:0]     ch_sel,
   output logic [COEFF_AW-1:0] coeff_addr,
   output logic                mac_clr,
   output logic                mac_en,
   output logic                rslt_vld,
   output logic [CH_W-1:0]     rslt_ch,
   output logic                busy,
   output logic                overrun,
   output logic                err_timeout
`ifdef SEQ_LEN_CHK_EN
   ,
   output logic                err_len
`endif
);

   localparam logic [CH_W-1:0]     LAST_CH  = CH_W'(NUM_CH - 1);
   localparam logic [COEFF_AW-1:0] ADDR_MAX = '1;

   sched_state_t state, state_nxt;
   logic         seq_cur;
   logic         wd_expire;
   logic         timeout_now;
   logic         ch_to;

   always_comb begin
      seq_cur = 1'b0;
      for (int i = 0; i < NUM_CH; i++)
         if (ch_sel == CH_W'(i))
            seq_cur = seq_in[i];
   end

   assign timeout_now = (state == S_WAIT_SEQ) && !seq_cur && wd_expire;
   assign busy        = (state != S_IDLE);

   seq_watchdog #(
      .TO_CYC (TO_CYC)
   ) u_watchdog (
      .clk    (clk),
      .rst    (rst),
      .clr    (state == S_START),
      .en     (state == S_WAIT_SEQ),
      .expire (wd_expire)
   );

   always_ff @(posedge clk) begin
      if (rst)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      q_start   = '0;
      mac_clr   = 1'b0;
      mac_en    = 1'b0;
      rslt_vld  = 1'b0;
      case (state)
         S_IDLE: begin
            if (wrt_smpl)
               state_nxt = S_START;
         end
         S_START: begin
            for (int i = 0; i < NUM_CH; i++)
               q_start[i] = (ch_sel == CH_W'(i));
            mac_clr   = 1'b1;
            state_nxt = S_WAIT_SEQ;
         end
         S_WAIT_SEQ: begin
            mac_en = seq_cur;
            if (seq_cur)
               state_nxt = S_RUN;
            else if (wd_expire)
               state_nxt = S_DONE;
         end
         S_RUN: begin
            mac_en = seq_cur;
            if (!seq_cur)
               state_nxt = S_DONE;
         end
         S_DONE: begin
            rslt_vld  = !ch_to;
            state_nxt = (ch_sel < LAST_CH) ? S_START : S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Channel pointer, coefficient address and sticky status flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         ch_sel      <= '0;
         coeff_addr  <= '0;
         rslt_ch     <= '0;
         ch_to       <= 1'b0;
         overrun     <= 1'b0;
         err_timeout <= 1'b0;
      end else begin
         if (state == S_IDLE && wrt_smpl)
            ch_sel <= '0;
         else if (state == S_DONE && ch_sel < LAST_CH)
            ch_sel <= ch_sel + CH_W'(1);

         if (state == S_START)
            coeff_addr <= '0;
         else if (mac_en && coeff_addr != ADDR_MAX)
            coeff_addr <= coeff_addr + COEFF_AW'(1);

         if (state == S_RUN && !seq_cur)
            rslt_ch <= ch_sel;

         if (state == S_START)
            ch_to <= 1'b0;
         else if (timeout_now)
            ch_to <= 1'b1;

         if (timeout_now)
            err_timeout <= 1'b1;

         if (busy && wrt_smpl)
            overrun <= 1'b1;
         else if (ovr_clr)
            overrun <= 1'b0;
      end
   end

`ifdef SEQ_LEN_CHK_EN
   localparam int LEN_W = $clog2(TAPS + 2);
   localparam logic [LEN_W-1:0] LEN_SAT = LEN_W'(TAPS + 1);

   logic [LEN_W-1:0] len_cnt;

   // Separate from coeff_addr because that one saturates below a possible overlength.
   always_ff @(posedge clk) begin
      if (rst) begin
         len_cnt <= '0;
         err_len <= 1'b0;
      end else begin
         if (state == S_START)
            len_cnt <= '0;
         else if (mac_en && len_cnt != LEN_SAT)
            len_cnt <= len_cnt + LEN_W'(1);

         if (state == S_DONE && len_cnt != LEN_W'(TAPS))
            err_len <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_eq_seq_sched.sv
// Directed self-checking bench for eq_seq_sched (NUM_CH=2, TAPS=8, COEFF_AW=4, TO_CYC=4).
module tb_eq_seq_sched;

   localparam int NUM_CH   = 2;
   localparam int TAPS     = 8;
   localparam int COEFF_AW = 4;
   localparam int TO_CYC   = 4;
   localparam int CH_W     = $clog2(NUM_CH) + 1;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                wrt_smpl = 1'b0;
   logic [NUM_CH-1:0]   seq_in = '0;
   logic                ovr_clr = 1'b0;
   logic [NUM_CH-1:0]   q_start;
   logic [CH_W-1:0]     ch_sel;
   logic [COEFF_AW-1:0] coeff_addr;
   logic                mac_clr;
   logic                mac_en;
   logic                rslt_vld;
   logic [CH_W-1:0]     rslt_ch;
   logic                busy;
   logic                overrun;
   logic                err_timeout;
`ifdef SEQ_LEN_CHK_EN
   logic                err_len;
`endif

   int vectors = 0;
   int miscompares = 0;

   eq_seq_sched #(
      .NUM_CH   (NUM_CH),
      .TAPS     (TAPS),
      .COEFF_AW (COEFF_AW),
      .TO_CYC   (TO_CYC)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .wrt_smpl    (wrt_smpl),
      .seq_in      (seq_in),
      .ovr_clr     (ovr_clr),
      .q_start     (q_start),
      .ch_sel      (ch_sel),
      .coeff_addr  (coeff_addr),
      .mac_clr     (mac_clr),
      .mac_en      (mac_en),
      .rslt_vld    (rslt_vld),
      .rslt_ch     (rslt_ch),
      .busy        (busy),
      .overrun     (overrun),
      .err_timeout (err_timeout)
`ifdef SEQ_LEN_CHK_EN
      ,
      .err_len     (err_len)
`endif
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   // Inputs change mid-low-phase; outputs are sampled 1 ns later, well before the next rising edge.
   task automatic applyStimulus(input logic w, input logic [1:0] s, input logic oc, input logic r);
      @(negedge clk);
      wrt_smpl = w;
      seq_in   = s;
      ovr_clr  = oc;
      rst      = r;
      #1;
   endtask

   // One readout: START, 'rise' idle wait cycles, 'len' seq cycles, fall, DONE.
   // inj: 0 none, 1 wrt_smpl at 3rd seq cycle, 2 wrt_smpl+ovr_clr together there.
   task automatic readout(input int ch, input int rise, input int len, input int inj, input bit toggle);
      logic [1:0] own, oth, s;
      int         exp_addr;
      own = 2'(1 << ch);
      oth = 2'(1 << (1 - ch));
      applyStimulus(1'b0, 2'b00, 1'b0, 1'b0);
      checkOutput("q_start", 32'(q_start), 32'(own));
      checkOutput("mac_clr", 32'(mac_clr), 32'd1);
      checkOutput("ch_sel", 32'(ch_sel), 32'(ch));
      for (int k = 0; k < rise; k++) begin
         applyStimulus(1'b0, toggle ? oth : 2'b00, 1'b0, 1'b0);
         checkOutput("mac_en_wait", 32'(mac_en), 32'd0);
      end
      for (int k = 0; k < len; k++) begin
         s = own | ((toggle && k[0]) ? oth : 2'b00);
         applyStimulus(inj != 0 && k == 2, s, inj == 2 && k == 2, 1'b0);
         exp_addr = (k > 15) ? 15 : k;
         checkOutput("mac_en_run", 32'(mac_en), 32'd1);
         checkOutput("coeff_addr", 32'(coeff_addr), 32'(exp_addr));
         checkOutput("q_start_run", 32'(q_start), 32'd0);
         if (inj != 0)
            checkOutput("overrun_run", 32'(overrun), 32'(k >= 3));
      end
      applyStimulus(1'b0, toggle ? oth : 2'b00, 1'b0, 1'b0);
      exp_addr = (len > 15) ? 15 : len;
      checkOutput("mac_en_fall", 32'(mac_en), 32'd0);
      checkOutput("coeff_hold", 32'(coeff_addr), 32'(exp_addr));
      applyStimulus(1'b0, 2'b00, 1'b0, 1'b0);
      checkOutput("rslt_vld", 32'(rslt_vld), 32'd1);
      checkOutput("rslt_ch", 32'(rslt_ch), 32'(ch));
   endtask

   task automatic idleCheck();
      applyStimulus(1'b0, 2'b00, 1'b0, 1'b0);
      checkOutput("busy_idle", 32'(busy), 32'd0);
      checkOutput("q_start_idle", 32'(q_start), 32'd0);
      checkOutput("rslt_vld_idle", 32'(rslt_vld), 32'd0);
   endtask

   initial begin
      // reset state
      applyStimulus(1'b0, 2'b00, 1'b0, 1'b1);
      applyStimulus(1'b0, 2'b00, 1'b0, 1'b1);
      applyStimulus(1'b0, 2'b00, 1'b0, 1'b0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_ch_sel", 32'(ch_sel), 32'd0);
      checkOutput("rst_coeff", 32'(coeff_addr), 32'd0);
      checkOutput("rst_rslt_ch", 32'(rslt_ch), 32'd0);
      checkOutput("rst_overrun", 32'(overrun), 32'd0);
      checkOutput("rst_err_to", 32'(err_timeout), 32'd0);
      checkOutput("rst_pulses", 32'({q_start, mac_clr, mac_en, rslt_vld}), 32'd0);

      // basic pass with overrun injection and cross-channel toggling on ch0
      applyStimulus(1'b1, 2'b00, 1'b0, 1'b0);
      checkOutput("busy_wrt", 32'(busy), 32'd0);
      readout(0, 1, 8, 1, 1'b1);
      readout(1, 1, 8, 0, 1'b0);
      idleCheck();
      checkOutput("overrun_kept", 32'(overrun), 32'd1);
`ifdef SEQ_LEN_CHK_EN
      checkOutput("err_len_ok", 32'(err_len), 32'd0);
`endif
      applyStimulus(1'b0, 2'b00, 1'b1, 1'b0);
      applyStimulus(1'b0, 2'b00, 1'b0, 1'b0);
      checkOutput("overrun_clr", 32'(overrun), 32'd0);

      // short sequence on ch0, and wrt_smpl+ovr_clr together while busy
      applyStimulus(1'b1, 2'b00, 1'b0, 1'b0);
      readout(0, 1, 7, 2, 1'b0);
      readout(1, 2, 8, 0, 1'b0);
      idleCheck();
      checkOutput("overrun_setwin", 32'(overrun), 32'd1);
`ifdef SEQ_LEN_CHK_EN
      checkOutput("err_len_set", 32'(err_len), 32'd1);
`endif

      // timeout on ch1
      applyStimulus(1'b1, 2'b00, 1'b0, 1'b0);
      readout(0, 1, 8, 0, 1'b0);
      applyStimulus(1'b0, 2'b00, 1'b0, 1'b0);
      checkOutput("to_q_start", 32'(q_start), 32'b10);
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'b0, 2'b00, 1'b0, 1'b0);
         checkOutput("to_mac_en", 32'(mac_en), 32'd0);
         checkOutput("to_early", 32'(err_timeout), 32'd0);
      end
      applyStimulus(1'b0, 2'b00, 1'b0, 1'b0);
      checkOutput("to_err", 32'(err_timeout), 32'd1);
      checkOutput("to_no_rslt", 32'(rslt_vld), 32'd0);
      checkOutput("to_busy_done", 32'(busy), 32'd1);
      idleCheck();

      // synchronous reset at the third mac_en cycle of ch0
      applyStimulus(1'b1, 2'b00, 1'b0, 1'b0);
      applyStimulus(1'b0, 2'b00, 1'b0, 1'b0);
      checkOutput("mr_q_start", 32'(q_start), 32'b01);
      applyStimulus(1'b0, 2'b00, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'b0, 2'b01, 1'b0, k == 2);
         checkOutput("mr_mac_en", 32'(mac_en), 32'd1);
         checkOutput("mr_coeff", 32'(coeff_addr), 32'(k));
      end
      applyStimulus(1'b0, 2'b01, 1'b0, 1'b0);
      checkOutput("mr_busy", 32'(busy), 32'd0);
      checkOutput("mr_mac_en_off", 32'(mac_en), 32'd0);
      checkOutput("mr_coeff_zero", 32'(coeff_addr), 32'd0);
      checkOutput("mr_err_to", 32'(err_timeout), 32'd0);
      applyStimulus(1'b0, 2'b00, 1'b0, 1'b0);
      checkOutput("mr_no_rslt", 32'(rslt_vld), 32'd0);
      applyStimulus(1'b1, 2'b00, 1'b0, 1'b0);
      readout(0, 1, 8, 0, 1'b0);
      readout(1, 1, 8, 0, 1'b1);
      idleCheck();

      // coefficient address saturates at 15 on an overlong sequence
      applyStimulus(1'b1, 2'b00, 1'b0, 1'b0);
      readout(0, 0, 18, 0, 1'b0);
      readout(1, 1, 8, 0, 1'b0);
      idleCheck();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
